// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame geometry.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Byte-out handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_oversampled_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = UART_DATA_BITS
) ();

    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ready;
    logic                 framing_error;
    logic                 overrun;

    modport master (
        output data,
        output data_valid,
        output framing_error,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        input  framing_error,
        input  overrun,
        output data_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level; both flops reset to ResetVal.
module sync_2ff #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled 8N1 UART receiver: centre-samples each bit on prescaler ticks and
// hands bytes out over a valid/ready interface with framing and overrun flags.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  tick,
    input  logic                  rx,
    output logic                  busy,
    uart_rx_oversampled_if.master rx_if
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    uart_rx_state_e         state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   stop_ok_q, stop_ok_d;
    logic                   stop_bad_q, stop_bad_d;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   framing_q;
    logic                   overrun_q;
    logic                   rx_s;

    sync_2ff #(
        .ResetVal (1'b1)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!rx_s) state_d = StStart;
            StStart: if (tick && cnt_q == CntHalf) state_d = rx_s ? StIdle : StData;
            StData:  if (tick && cnt_q == CntLast && idx_q == IdxLast) state_d = StStop;
            StStop:  if (tick && cnt_q == CntLast) state_d = rx_s ? StIdle : StBreak;
            StBreak: if (rx_s) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (!enable) state_d = StIdle;
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    // Counters move only on tick; every phase boundary restarts the tick count.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        stop_ok_d  = 1'b0;
        stop_bad_d = 1'b0;
        unique case (state_q)
            StIdle, StBreak: begin
                cnt_d = '0;
                idx_d = '0;
            end
            StStart: begin
                if (tick) cnt_d = (cnt_q == CntHalf) ? '0 : cnt_q + CntW'(1);
            end
            StData: begin
                if (tick) begin
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + IdxW'(1);
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (cnt_q == CntLast) begin
                        cnt_d      = '0;
                        stop_ok_d  = rx_s;
                        stop_bad_d = !rx_s;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                cnt_d = '0;
                idx_d = '0;
            end
        endcase
        if (!enable) begin
            cnt_d      = '0;
            idx_d      = '0;
            stop_ok_d  = 1'b0;
            stop_bad_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            stop_ok_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            stop_ok_q  <= stop_ok_d;
            stop_bad_q <= stop_bad_d;
        end
    end

    // A commit coinciding with an accept replaces the byte instead of overrunning.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            framing_q <= stop_bad_q;
            overrun_q <= 1'b0;
            if (stop_ok_q) begin
                if (!valid_q || rx_if.data_ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && rx_if.data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.data          = data_q;
    assign rx_if.data_valid    = valid_q;
    assign rx_if.framing_error = framing_q;
    assign rx_if.overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: directed scenarios plus random frames checked
// against a frame-level model of what the line should deliver.
module tb_uart_rx_oversampled;

    localparam int unsigned OS       = 16;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned BIT_CLK  = OS * TICK_DIV;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic tick;
    logic rx;
    logic busy;

    int checks = 0;
    int errors = 0;

    byte unsigned rcv_q[$];
    int   fe_cnt       = 0;
    int   ovr_cnt      = 0;
    int   valid_rises  = 0;
    int   valid_cycles = 0;
    logic valid_prev   = 1'b0;

    uart_rx_oversampled_if #(.DATA_BITS(8)) bus ();

    uart_rx_oversampled #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .tick   (tick),
        .rx     (rx),
        .busy   (busy),
        .rx_if  (bus)
    );

    always #5 clock = ~clock;

    initial begin : tick_gen
        int unsigned div;
        div  = 0;
        tick = 1'b0;
        forever begin
            @(negedge clock);
            tick = (div == TICK_DIV - 1);
            div  = (div + 1) % TICK_DIV;
        end
    end

    // Observe the consumer side a little after each falling edge.
    always @(negedge clock) begin
        #2;
        if (!reset) begin
            if (bus.data_valid && bus.data_ready) rcv_q.push_back(bus.data);
            if (bus.framing_error) fe_cnt++;
            if (bus.overrun) ovr_cnt++;
            if (bus.data_valid) valid_cycles++;
            if (bus.data_valid && !valid_prev) valid_rises++;
        end
        valid_prev = bus.data_valid;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] frame_line(input byte unsigned b, input logic stop);
        return {stop, b, 1'b0};
    endfunction

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLK) @(negedge clock);
    endtask

    task automatic send_line(input logic [9:0] line);
        for (int i = 0; i < 10; i++) drive_bit(line[i]);
    endtask

    // Drives nfull whole line bits, then half of the next one.
    task automatic send_partial(input logic [9:0] line, input int nfull);
        for (int i = 0; i < nfull; i++) drive_bit(line[i]);
        rx = line[nfull];
        repeat (BIT_CLK / 2) @(negedge clock);
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n;
        n = 0;
        while (busy !== lvl && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check_eq(tag, 32'(busy), 32'(lvl));
    endtask

    initial begin
        int fe0, ovr0, vr0, vc0, n0;
        byte unsigned exp_q[$];
        int exp_fe;
        logic [9:0] line;

        reset = 1'b1;
        enable = 1'b1;
        rx = 1'b1;
        bus.data_ready = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_data", 32'(bus.data), 32'h0);
        check_eq("rst_valid", 32'(bus.data_valid), 32'h0);
        check_eq("rst_fe", 32'(bus.framing_error), 32'h0);
        check_eq("rst_ovr", 32'(bus.overrun), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Single frame with consumer always ready.
        fe0 = fe_cnt; vc0 = valid_cycles;
        send_line(frame_line(8'hA5, 1'b1));
        drive_bit(1'b1);
        check_eq("single_cnt", 32'(rcv_q.size()), 32'd1);
        check_eq("single_data", 32'(rcv_q[$]), 32'hA5);
        check_eq("single_fe", 32'(fe_cnt - fe0), 32'd0);
        check_eq("single_vcyc", 32'(valid_cycles - vc0), 32'd1);

        // Start-bit glitch of three ticks.
        fe0 = fe_cnt; ovr0 = ovr_cnt; vr0 = valid_rises;
        rx = 1'b0;
        repeat (8) @(negedge clock);
        check_eq("glitch_start", 32'(busy), 32'd1);
        repeat (3 * TICK_DIV - 8) @(negedge clock);
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clock);
        check_eq("glitch_idle", 32'(busy), 32'd0);
        check_eq("glitch_flags", 32'(fe_cnt - fe0 + ovr_cnt - ovr0 + valid_rises - vr0), 32'd0);

        // Framing error followed by a long break, then a clean frame.
        fe0 = fe_cnt; vr0 = valid_rises; n0 = rcv_q.size();
        send_line(frame_line(8'h3C, 1'b0));
        repeat (40) drive_bit(1'b0);
        check_eq("brk_fe", 32'(fe_cnt - fe0), 32'd1);
        check_eq("brk_novalid", 32'(valid_rises - vr0), 32'd0);
        check_eq("brk_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (8) @(negedge clock);
        check_eq("brk_exit", 32'(busy), 32'd0);
        send_line(frame_line(8'h55, 1'b1));
        drive_bit(1'b1);
        check_eq("brk_next_cnt", 32'(rcv_q.size() - n0), 32'd1);
        check_eq("brk_next_data", 32'(rcv_q[$]), 32'h55);

        // Overrun: second byte lands while the first is still unaccepted.
        ovr0 = ovr_cnt; n0 = rcv_q.size();
        bus.data_ready = 1'b0;
        send_line(frame_line(8'h11, 1'b1));
        send_line(frame_line(8'h22, 1'b1));
        drive_bit(1'b1);
        check_eq("ovr_data", 32'(bus.data), 32'h11);
        check_eq("ovr_valid", 32'(bus.data_valid), 32'd1);
        check_eq("ovr_pulse", 32'(ovr_cnt - ovr0), 32'd1);
        check_eq("ovr_noacc", 32'(rcv_q.size() - n0), 32'd0);
        bus.data_ready = 1'b1;
        @(negedge clock);
        check_eq("ovr_clear", 32'(bus.data_valid), 32'd0);
        check_eq("ovr_acc", 32'(rcv_q[$]), 32'h11);

        // Accept lands on the same edge as the next commit.
        ovr0 = ovr_cnt; n0 = rcv_q.size();
        bus.data_ready = 1'b0;
        send_line(frame_line(8'h11, 1'b1));
        fork
            send_line(frame_line(8'h22, 1'b1));
            begin
                wait_busy(1'b1, "same_busy_hi");
                wait_busy(1'b0, "same_busy_lo");
                bus.data_ready = 1'b1;
                @(negedge clock);
                check_eq("same_data", 32'(bus.data), 32'h22);
                check_eq("same_valid", 32'(bus.data_valid), 32'd1);
            end
        join
        drive_bit(1'b1);
        check_eq("same_noovr", 32'(ovr_cnt - ovr0), 32'd0);
        check_eq("same_cnt", 32'(rcv_q.size() - n0), 32'd2);
        check_eq("same_first", 32'(rcv_q[n0]), 32'h11);
        check_eq("same_second", 32'(rcv_q[$]), 32'h22);

        // Disable during data bit 3.
        fe0 = fe_cnt; ovr0 = ovr_cnt; vr0 = valid_rises;
        send_partial(frame_line(8'hAB, 1'b1), 4);
        enable = 1'b0;
        rx = 1'b1;
        @(negedge clock);
        check_eq("dis_idle", 32'(busy), 32'd0);
        repeat (4) @(negedge clock);
        enable = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clock);
        check_eq("dis_data_kept", 32'(bus.data), 32'h22);
        check_eq("dis_flags", 32'(fe_cnt - fe0 + ovr_cnt - ovr0 + valid_rises - vr0), 32'd0);

        // Asynchronous reset during data bit 5, checked between clock edges.
        send_partial(frame_line(8'h5A, 1'b1), 6);
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_data", 32'(bus.data), 32'h0);
        check_eq("arst_valid", 32'(bus.data_valid), 32'd0);
        @(negedge clock);
        rx = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        fe0 = fe_cnt; n0 = rcv_q.size();
        send_line(frame_line(8'hF0, 1'b1));
        drive_bit(1'b1);
        check_eq("post_cnt", 32'(rcv_q.size() - n0), 32'd1);
        check_eq("post_data", 32'(rcv_q[$]), 32'hF0);
        check_eq("post_fe", 32'(fe_cnt - fe0), 32'd0);

        // Random frames: a good stop bit yields its byte, a bad one a framing error.
        fe0 = fe_cnt; n0 = rcv_q.size(); exp_fe = 0;
        for (int f = 0; f < 12; f++) begin
            line = frame_line(8'($urandom), ($urandom_range(3) != 0));
            repeat ($urandom_range(3)) @(negedge clock);
            send_line(line);
            if (line[9]) exp_q.push_back(line[8:1]);
            else exp_fe++;
            repeat ($urandom_range(2) + (line[9] ? 0 : 1)) drive_bit(1'b1);
        end
        drive_bit(1'b1);
        check_eq("rnd_cnt", 32'(rcv_q.size() - n0), 32'(exp_q.size()));
        check_eq("rnd_fe", 32'(fe_cnt - fe0), 32'(exp_fe));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (n0 + i < rcv_q.size()) check_eq("rnd_data", 32'(rcv_q[n0 + i]), 32'(exp_q[i]));
            else check_eq("rnd_missing", 32'hFFFF_FFFF, 32'(exp_q[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Serial UART receiver that samples the asynchronous `rx` line against the oversampling tick produced by the team's prescaler. It recovers 8N1 frames (LSB first), centre-samples each bit, and presents each received byte through a valid/ready handshake with framing and overrun flags. It sits between the board pin and the byte consumer, on the receive side of the UART.

## Interface
- `DATA_BITS`, default 8: data bits per frame.
- `OVERSAMPLE`, default 16: ticks per bit period. Must be even and at least 4.
- `clock` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: receiver enable. While low, the FSM is forced to IDLE.
- `tick` in 1: one-`clock`-wide pulse at baud×OVERSAMPLE, supplied by the prescaler.
- `rx` in 1: asynchronous serial input. The line idles high.
- `data` out DATA_BITS: received byte. Held stable while `data_valid` is high.
- `data_valid` out 1: byte available. Stays high until the handshake completes.
- `data_ready` in 1: the consumer accepts the byte when `data_valid && data_ready` on a `clock` edge.
- `framing_error` out 1: one-cycle pulse when the stop bit samples low.
- `overrun` out 1: one-cycle pulse when a new byte completes while `data_valid` is still high.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer. Both flops reset to 1. All FSM decisions use the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** on `rx_s == 0`, go to START and clear the tick counter.
  - **START:** count ticks. At tick OVERSAMPLE/2, if `rx_s == 0`, go to DATA and clear the counter. Otherwise the start bit is a glitch: return to IDLE with no flag.
  - **DATA:** at every OVERSAMPLE-th tick, shift in `rx_s` LSB-first and increment the bit index. After DATA_BITS samples, go to STOP.
  - **STOP:** at the OVERSAMPLE-th tick, sample `rx_s`.
    - If 1: commit the byte and go to IDLE.
    - If 0: pulse `framing_error`, do not commit, and go to BREAK.
  - **BREAK:** wait for `rx_s == 1`, then go to IDLE.
- Commit rules:
  - If `data_valid` is low, or is high and being accepted in the same cycle, load `data` and set `data_valid`.
  - Otherwise pulse `overrun`, keep the old `data`, drop the new byte, and leave `data_valid` high.
- The handshake clears `data_valid` on the edge where `data_valid && data_ready`, unless a commit happens in the same cycle; in that case the new byte is loaded and `data_valid` stays 1.
- The tick counter and bit index advance only on `tick`. Between ticks they hold.
- `enable` low: the FSM returns to IDLE on the next edge and any partial frame is discarded. `data` and `data_valid` are unaffected, and the handshake still works.

## Timing
- Reset values: `data` = 0, `data_valid` = 0, `framing_error` = 0, `overrun` = 0, `busy` = 0. The FSM is in IDLE, all counters are 0, and the synchronizer flops are 1.
- `rx` to `rx_s` latency: 2 `clock` edges.
- Sample points, measured in ticks after the start-edge detection:
  - start check at OVERSAMPLE/2;
  - data bit k sampled at OVERSAMPLE/2 + (k+1)·OVERSAMPLE;
  - stop bit sampled at OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE.
- `data_valid` / `framing_error` / `overrun` rise on the `clock` edge after the stop-sample tick edge (registered, 1-cycle latency).
- `busy` falls on the same edge that returns the FSM to IDLE.
- Back-to-back frames are supported. A start edge arriving on the first IDLE cycle is accepted.
- Reset asserted mid-frame returns everything to reset values immediately, without waiting for a clock.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP, BREAK;
  - default constants `UART_OVERSAMPLE` = 16 and `UART_DATA_BITS` = 8.
- Sub-module `sync_2ff`:
  - generic 2-flop synchronizer with parameterized reset value;
  - reused later by the transmitter-side CTS input.
- Counter widths: `$clog2(OVERSAMPLE)` for the tick counter and `$clog2(DATA_BITS+1)` for the bit index.

## Test plan
- **Single frame:** tick every 4 clocks, OVERSAMPLE = 16. Send 0xA5 with the stop bit high and `data_ready` held 1. Expect `data` = 0xA5, `data_valid` high for 1 cycle, `framing_error` = 0.
- **Glitch:** a 3-tick low pulse on an idle line returns the FSM to IDLE. `busy` drops, and `data_valid`, `framing_error` and `overrun` stay 0.
- **Framing error / break:** send 0x3C with the stop bit low, then hold `rx` low for 40 bit times. Expect one `framing_error` pulse, `data_valid` = 0, the FSM stays in BREAK until `rx` goes high, then 0x55 is received cleanly.
- **Overrun:** with `data_ready` = 0, send 0x11 then 0x22. Expect `data` = 0x11, `data_valid` = 1, one `overrun` pulse at the end of 0x22. Raising `data_ready` then clears `data_valid`.
- **Same-cycle accept and commit:** assert `data_ready` exactly on the commit edge of the second byte. Expect `data` = 0x22, `data_valid` stays 1, no `overrun`.
- **Mid-frame disable and reset:** deassert `enable` during bit 3, and separately assert `reset` during bit 5. Expect an immediate return to IDLE / reset values and no output pulses. The next 0xF0 frame is received correctly.
